// File: rtl/dft_power_peak_search_if.sv
// Bundle of the DFT power/peak search data path.
// master : frame producer / result consumer (drives A_*_i, valid_i, pwr_ready_i).
// slave  : the power/peak search block (drives the power stream, peak and status outputs).
//   A_real_i, A_imag_i   NUM_BINS signed accumulator values, ACCUM_WIDTH bits each
//   valid_i              one-cycle pulse, A_*_i hold a complete result
//   pwr_o, bin_idx_o     per-bin power stream, pwr_valid_o/pwr_ready_i handshake, last_o
//   peak_pwr_o, peak_bin_o, peak_valid_o   frame maximum
//   busy_o, overrun_o    status
interface dft_power_peak_search_if #(
   parameter int ACCUM_WIDTH = 48,
   parameter int NUM_BINS    = 16
);
   localparam int IDX_WIDTH = $clog2(NUM_BINS);
   localparam int PWR_WIDTH = 2 * ACCUM_WIDTH + 1;

   logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] A_real_i;
   logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] A_imag_i;
   logic                                 valid_i;
   logic [PWR_WIDTH-1:0]                 pwr_o;
   logic [IDX_WIDTH-1:0]                 bin_idx_o;
   logic                                 pwr_valid_o;
   logic                                 pwr_ready_i;
   logic                                 last_o;
   logic [PWR_WIDTH-1:0]                 peak_pwr_o;
   logic [IDX_WIDTH-1:0]                 peak_bin_o;
   logic                                 peak_valid_o;
   logic                                 busy_o;
   logic                                 overrun_o;

   modport master (
      output A_real_i, A_imag_i, valid_i, pwr_ready_i,
      input  pwr_o, bin_idx_o, pwr_valid_o, last_o,
      input  peak_pwr_o, peak_bin_o, peak_valid_o, busy_o, overrun_o
   );

   modport slave (
      input  A_real_i, A_imag_i, valid_i, pwr_ready_i,
      output pwr_o, bin_idx_o, pwr_valid_o, last_o,
      output peak_pwr_o, peak_bin_o, peak_valid_o, busy_o, overrun_o
   );
endinterface

// File: rtl/dft_power_peak_search.sv
// Per-bin power computation and peak search over one DFT result.
// A captured frame is walked bin by bin: CALC registers re^2 + im^2 at full precision,
// SEND presents it on a valid/ready stream, PEAK emits the frame maximum for one cycle.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    dft_power_peak_search_if.slave (frame input, power stream, peak, status)
module dft_power_peak_search #(
   parameter int ACCUM_WIDTH = 48,
   parameter int NUM_BINS    = 16
) (
   input logic                    clk_i,
   input logic                    rst_i,
   dft_power_peak_search_if.slave bus
);
   localparam int IDX_WIDTH = $clog2(NUM_BINS);
   localparam int PWR_WIDTH = 2 * ACCUM_WIDTH + 1;
   localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_BINS - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StSend, StPeak} state_e;

   state_e                               state_q;
   logic [IDX_WIDTH-1:0]                 idx_q;
   logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] a_real_q;
   logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] a_imag_q;
   logic [PWR_WIDTH-1:0]                 pwr_q;
   logic [IDX_WIDTH-1:0]                 bin_idx_q;
   logic                                 pwr_valid_q;
   logic                                 last_q;
   logic [PWR_WIDTH-1:0]                 peak_pwr_q;
   logic [IDX_WIDTH-1:0]                 peak_bin_q;
   logic                                 peak_valid_q;
   logic                                 busy_q;
   logic                                 overrun_q;

   logic signed [ACCUM_WIDTH-1:0] re_sel;
   logic signed [ACCUM_WIDTH-1:0] im_sel;
   logic signed [PWR_WIDTH-1:0]   re_ext;
   logic signed [PWR_WIDTH-1:0]   im_ext;
   logic [PWR_WIDTH-1:0]          cur_pwr;
   logic                          handshake;

   // Sign-extend to PWR_WIDTH before squaring; the sum of two squares of the most
   // negative value is 2^(2*ACCUM_WIDTH-1), which fits without overflow.
   always_comb begin
      re_sel  = $signed(a_real_q[idx_q]);
      im_sel  = $signed(a_imag_q[idx_q]);
      re_ext  = PWR_WIDTH'(re_sel);
      im_ext  = PWR_WIDTH'(im_sel);
      cur_pwr = $unsigned(re_ext * re_ext + im_ext * im_ext);
   end

   assign handshake = (state_q == StSend) && pwr_valid_q && bus.pwr_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         a_real_q     <= '0;
         a_imag_q     <= '0;
         pwr_q        <= '0;
         bin_idx_q    <= '0;
         pwr_valid_q  <= 1'b0;
         last_q       <= 1'b0;
         peak_pwr_q   <= '0;
         peak_bin_q   <= '0;
         peak_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         peak_valid_q <= 1'b0;
         // A new result while a frame is in flight is dropped and flagged.
         overrun_q    <= bus.valid_i && (state_q != StIdle);
         unique case (state_q)
            StIdle: begin
               if (bus.valid_i) begin
                  a_real_q <= bus.A_real_i;
                  a_imag_q <= bus.A_imag_i;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StCalc;
               end
            end
            StCalc: begin
               pwr_q       <= cur_pwr;
               bin_idx_q   <= idx_q;
               last_q      <= (idx_q == LastIdx);
               pwr_valid_q <= 1'b1;
               state_q     <= StSend;
            end
            StSend: begin
               if (handshake) begin
                  pwr_valid_q <= 1'b0;
                  last_q      <= 1'b0;
                  // Strict compare keeps the lowest index on ties.
                  if ((idx_q == '0) || (pwr_q > peak_pwr_q)) begin
                     peak_pwr_q <= pwr_q;
                     peak_bin_q <= idx_q;
                  end
                  if (idx_q != LastIdx) begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= StCalc;
                  end else begin
                     state_q <= StPeak;
                  end
               end
            end
            StPeak: begin
               peak_valid_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.pwr_o        = pwr_q;
   assign bus.bin_idx_o    = bin_idx_q;
   assign bus.pwr_valid_o  = pwr_valid_q;
   assign bus.last_o       = last_q;
   assign bus.peak_pwr_o   = peak_pwr_q;
   assign bus.peak_bin_o   = peak_bin_q;
   assign bus.peak_valid_o = peak_valid_q;
   assign bus.busy_o       = busy_q;
   assign bus.overrun_o    = overrun_q;
endmodule
